// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arbiter
// Description : Two-port register-file write arbiter. Each port has a
//               one-entry buffer. The older entry is issued first; entries
//               accepted on the same edge are ordered by a round-robin
//               pointer. Writes to r0 are accepted and dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter (
  input  logic        clk,
  input  logic        rstd,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        wren,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_reg,
  output logic [31:0] pending,
  output logic [15:0] wr_count
);

  // Buffer state
  logic        full0, full1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        tie;    // both entries were accepted on the same edge
  logic        older;  // 0: port 0 holds the older entry, 1: port 1
  logic        rr;     // tie-break pointer: 0 favours port 0

  logic        acc0, acc1;
  logic        gnt0, gnt1;

  // A buffer can only be refilled on the edge after it has drained
  assign req0_ready = ~full0;
  assign req1_ready = ~full1;

  // Transfers to r0 complete the handshake but never occupy the buffer
  assign acc0 = req0_valid & ~full0 & (req0_addr != 5'd0);
  assign acc1 = req1_valid & ~full1 & (req1_addr != 5'd0);

  // Grant selection from buffer contents only
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (full0 && full1) begin
      if (tie) begin
        gnt1 = rr;
        gnt0 = ~rr;
      end else begin
        gnt1 = older;
        gnt0 = ~older;
      end
    end else begin
      gnt0 = full0;
      gnt1 = full1;
    end
  end

  // Register-file write port and hazard view
  always_comb begin
    wren    = 1'b1;
    wr_addr = 5'd0;
    wr_reg  = 32'd0;
    pending = 32'd0;
    if (gnt0) begin
      wren    = 1'b0;
      wr_addr = addr0;
      wr_reg  = data0;
    end else if (gnt1) begin
      wren    = 1'b0;
      wr_addr = addr1;
      wr_reg  = data1;
    end
    if (full0) pending[addr0] = 1'b1;
    if (full1) pending[addr1] = 1'b1;
  end

  // Buffer fill/drain, age tracking, tie-break pointer and write counter
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      full0    <= 1'b0;
      full1    <= 1'b0;
      addr0    <= 5'd0;
      addr1    <= 5'd0;
      data0    <= 32'd0;
      data1    <= 32'd0;
      tie      <= 1'b0;
      older    <= 1'b0;
      rr       <= 1'b0;
      wr_count <= 16'd0;
    end else begin
      full0 <= acc0 | (full0 & ~gnt0);
      full1 <= acc1 | (full1 & ~gnt1);
      if (acc0) begin
        addr0 <= req0_addr;
        data0 <= req0_data;
      end
      if (acc1) begin
        addr1 <= req1_addr;
        data1 <= req1_data;
      end
      tie <= acc0 & acc1;
      // A newcomer joining a still-occupied partner is the younger entry
      if (acc1 && full0 && !gnt0)
        older <= 1'b0;
      else if (acc0 && full1 && !gnt1)
        older <= 1'b1;
      // Both full with a tie always resolves this edge
      if (full0 && full1 && tie)
        rr <= ~rr;
      if (!wren)
        wr_count <= wr_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wr_arbiter
// Description : Self-checking bench for rf_wr_arbiter. A timestamp-based
//               reference model is compared against the DUT every cycle,
//               alongside hand-computed expectations for directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        v [2];
  logic [4:0]  a [2];
  logic [31:0] d [2];
  logic        ready0, ready1;
  logic        wren;
  logic [4:0]  wr_addr;
  logic [31:0] wr_reg;
  logic [31:0] pending;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  rf_wr_arbiter dut (
    .clk       (clk),
    .rstd      (rstd),
    .req0_valid(v[0]),
    .req0_addr (a[0]),
    .req0_data (d[0]),
    .req0_ready(ready0),
    .req1_valid(v[1]),
    .req1_addr (a[1]),
    .req1_data (d[1]),
    .req1_ready(ready1),
    .wren      (wren),
    .wr_addr   (wr_addr),
    .wr_reg    (wr_reg),
    .pending   (pending),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each buffered entry carries the edge number it was
  // accepted on; smallest stamp is issued first, equal stamps go by rr.
  logic        m_full  [2];
  logic [4:0]  m_addr  [2];
  logic [31:0] m_data  [2];
  int          m_stamp [2];
  logic        m_rr;
  int          m_total;
  int          m_edge;
  int          m_g;
  logic [31:0] m_pend;

  // Model grant and hazard view
  always_comb begin
    m_g    = -1;
    m_pend = 32'd0;
    if (m_full[0] && m_full[1]) begin
      if (m_stamp[0] < m_stamp[1])      m_g = 0;
      else if (m_stamp[1] < m_stamp[0]) m_g = 1;
      else                              m_g = m_rr ? 1 : 0;
    end else if (m_full[0]) m_g = 0;
    else if (m_full[1])     m_g = 1;
    for (int p = 0; p < 2; p++)
      if (m_full[p]) m_pend[m_addr[p]] = 1'b1;
  end

  // Model state update
  always @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int p = 0; p < 2; p++) begin
        m_full[p]  <= 1'b0;
        m_addr[p]  <= 5'd0;
        m_data[p]  <= 32'd0;
        m_stamp[p] <= 0;
      end
      m_rr    <= 1'b0;
      m_total <= 0;
      m_edge  <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_g >= 0) m_total <= m_total + 1;
      if (m_full[0] && m_full[1] && m_stamp[0] == m_stamp[1]) m_rr <= ~m_rr;
      for (int p = 0; p < 2; p++) begin
        if (v[p] && !m_full[p] && a[p] != 5'd0) begin
          m_full[p]  <= 1'b1;
          m_addr[p]  <= a[p];
          m_data[p]  <= d[p];
          m_stamp[p] <= m_edge;
        end else if (m_g == p) begin
          m_full[p] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_wren",    {31'd0, wren},    {31'd0, (m_g < 0)});
    chk("cyc_wr_addr", {27'd0, wr_addr}, (m_g < 0) ? 32'd0 : {27'd0, m_addr[m_g]});
    chk("cyc_wr_reg",  wr_reg,           (m_g < 0) ? 32'd0 : m_data[m_g]);
    chk("cyc_pending", pending,          m_pend);
    chk("cyc_count",   {16'd0, wr_count}, {16'd0, m_total[15:0]});
    chk("cyc_ready0",  {31'd0, ready0},  {31'd0, ~m_full[0]});
    chk("cyc_ready1",  {31'd0, ready1},  {31'd0, ~m_full[1]});
  end

  task automatic drive(input int p, input logic [4:0] ad, input logic [31:0] da);
    v[p] = 1'b1;
    a[p] = ad;
    d[p] = da;
  endtask

  task automatic idle();
    v[0] = 1'b0;
    v[1] = 1'b0;
  endtask

  initial begin
    int cyc;
    idle();
    a[0] = 5'd0; a[1] = 5'd0; d[0] = 32'd0; d[1] = 32'd0;
    #1;
    chk("rst_wren",   {31'd0, wren},   32'd1);
    chk("rst_ready0", {31'd0, ready0}, 32'd1);
    chk("rst_ready1", {31'd0, ready1}, 32'd1);
    #11 rstd = 1'b1;
    @(negedge clk);

    // Single uncontested write
    drive(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk); idle();
    chk("single_wren",    {31'd0, wren},    32'd0);
    chk("single_addr",    {27'd0, wr_addr}, 32'd5);
    chk("single_data",    wr_reg,           32'hDEADBEEF);
    chk("single_pending", pending,          32'h0000_0020);
    chk("single_ready0",  {31'd0, ready0},  32'd0);
    @(negedge clk);
    chk("single_done",    {31'd0, wren},     32'd1);
    chk("single_count",   {16'd0, wr_count}, 32'd1);
    chk("single_pclr",    pending,           32'd0);

    // Tie: rr starts at port 0, then flips to port 1
    drive(0, 5'd3, 32'h11); drive(1, 5'd4, 32'h22);
    @(negedge clk); idle();
    chk("tie1_addr_a", {27'd0, wr_addr}, 32'd3);
    chk("tie1_data_a", wr_reg,           32'h11);
    chk("tie1_pend",   pending,          32'h0000_0018);
    @(negedge clk);
    chk("tie1_addr_b", {27'd0, wr_addr}, 32'd4);
    chk("tie1_data_b", wr_reg,           32'h22);
    @(negedge clk);
    chk("tie1_count",  {16'd0, wr_count}, 32'd3);
    drive(0, 5'd3, 32'h11); drive(1, 5'd4, 32'h22);
    @(negedge clk); idle();
    chk("tie2_addr_a", {27'd0, wr_addr}, 32'd4);
    @(negedge clk);
    chk("tie2_addr_b", {27'd0, wr_addr}, 32'd3);
    @(negedge clk);
    chk("tie2_count",  {16'd0, wr_count}, 32'd5);

    // Same-register ordering: port 1 first, then port 0
    drive(1, 5'd7, 32'hA);
    @(negedge clk); idle(); drive(0, 5'd7, 32'hB);
    chk("ord_first_addr", {27'd0, wr_addr}, 32'd7);
    chk("ord_first_data", wr_reg,           32'hA);
    @(negedge clk); idle();
    chk("ord_second_addr", {27'd0, wr_addr}, 32'd7);
    chk("ord_second_data", wr_reg,           32'hB);
    @(negedge clk);
    chk("ord_count", {16'd0, wr_count}, 32'd7);

    // r0 discard
    drive(0, 5'd0, 32'hFFFF);
    @(negedge clk); idle();
    chk("r0_ready", {31'd0, ready0},    32'd1);
    chk("r0_wren",  {31'd0, wren},      32'd1);
    chk("r0_pend",  pending,            32'd0);
    chk("r0_count", {16'd0, wr_count},  32'd7);
    @(negedge clk);
    chk("r0_wren2", {31'd0, wren},      32'd1);

    // Asynchronous reset with both buffers full
    drive(0, 5'd12, 32'h12); drive(1, 5'd13, 32'h13);
    @(posedge clk); #2;
    chk("mid_full", pending, 32'h0000_3000);
    rstd = 1'b0;
    #1;
    chk("mid_wren",   {31'd0, wren},     32'd1);
    chk("mid_pend",   pending,           32'd0);
    chk("mid_count",  {16'd0, wr_count}, 32'd0);
    chk("mid_ready0", {31'd0, ready0},   32'd1);
    chk("mid_ready1", {31'd0, ready1},   32'd1);
    idle();
    #1 rstd = 1'b1;
    @(negedge clk);
    chk("post_rst_wren", {31'd0, wren}, 32'd1);
    drive(0, 5'd2, 32'h5);
    @(negedge clk); idle();
    chk("post_rst_addr", {27'd0, wr_addr}, 32'd2);
    @(negedge clk);
    chk("post_rst_count", {16'd0, wr_count}, 32'd1);

    // Counter wrap after 65536 writes from reset
    rstd = 1'b0;
    #1 rstd = 1'b1;
    cyc = 0;
    while (m_total < 65536 && cyc < 70000) begin
      drive(0, 5'((cyc % 31) + 1), 32'(cyc));
      drive(1, 5'(((cyc + 7) % 31) + 1), ~32'(cyc));
      @(negedge clk);
      cyc++;
    end
    idle();
    chk("wrap_reached", {31'd0, (m_total == 65536)}, 32'd1);
    chk("wrap_count",   {16'd0, wr_count},            32'd0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
